clk_en_gen: RTL and testbench

Multi-channel, runtime-programmable clock-enable generator for the core. Each of `N_CH` channels divides the single reference clock into a periodic `clk_en` strobe with a programmable period and high time, plus a one-cycle `tick` at period start. Configuration goes through a valid/ready write port. A global `sync` realigns all channels. The block feeds the core pipeline and slow peripherals, which run from `clk` gated by these enables.

---
 rtl/core_config_pkg.sv | 16 +
 rtl/clk_en_channel.sv | 78 +++++++
 rtl/clk_en_gen.sv | 53 +++++
 tb/tb_clk_en_gen.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// core_config_pkg: core clocking constants and the clock-enable generator config type.
// The generator's reset config derives from the reference/core frequency ratio and duty.
package core_config_pkg;
    localparam int REF_CLK_FREQ    = 100_000_000;
    localparam int CORE_CLK_FREQ   = 25_000_000;
    localparam int CORE_CLK_DUTY   = 50;
    localparam int CLKGEN_N_CH     = 2;
    localparam int CLKGEN_CNT_W    = 16;
    localparam int CLKGEN_DEF_DIV  = REF_CLK_FREQ / CORE_CLK_FREQ;
    localparam int CLKGEN_DEF_HIGH = CLKGEN_DEF_DIV * CORE_CLK_DUTY / 100;

    typedef struct packed {
        logic [CLKGEN_CNT_W-1:0] div;
        logic [CLKGEN_CNT_W-1:0] high;
    } clkgen_cfg_t;
endpackage

// File: rtl/clk_en_channel.sv
// clk_en_channel: one divider counter with its active config and registered clk_en/tick.
// With CLKGEN_SHADOW_EN a write waits in a shadow until the period boundary, sync or disable.
module clk_en_channel
    import core_config_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic        i_sync,
    input  logic        i_wr,
    input  clkgen_cfg_t i_cfg,
`ifdef CLKGEN_SHADOW_EN
    output logic        o_pending,
`endif
    output logic        o_clk_en,
    output logic        o_tick
);
    localparam clkgen_cfg_t DEF_CFG = '{div:  CLKGEN_CNT_W'(CLKGEN_DEF_DIV),
                                        high: CLKGEN_CNT_W'(CLKGEN_DEF_HIGH)};

    clkgen_cfg_t             r_cfg;
    logic [CLKGEN_CNT_W-1:0] r_cnt;
    logic                    r_clk_en;
    logic                    r_tick;
    logic [CLKGEN_CNT_W-1:0] w_last;
    logic                    w_wrap;
    logic                    w_restart;
    logic                    w_zero;

    // div of 0 behaves as 1, so the last count is clamped at 0
    assign w_last    = (r_cfg.div == '0) ? '0 : r_cfg.div - 1'b1;
    assign w_wrap    = r_cnt >= w_last;
    assign w_restart = !i_en || i_sync;
    assign o_clk_en  = r_clk_en;
    assign o_tick    = r_tick;

`ifdef CLKGEN_SHADOW_EN
    clkgen_cfg_t r_shadow;
    logic        r_pending;
    assign w_zero    = w_restart || w_wrap;
    assign o_pending = r_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg     <= DEF_CFG;
            r_shadow  <= DEF_CFG;
            r_pending <= 1'b0;
        end else if (i_wr && w_zero) begin
            r_cfg <= i_cfg;
        end else if (i_wr) begin
            r_shadow  <= i_cfg;
            r_pending <= 1'b1;
        end else if (r_pending && w_zero) begin
            r_cfg     <= r_shadow;
            r_pending <= 1'b0;
        end
    end
`else
    assign w_zero = w_restart || w_wrap || i_wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cfg <= DEF_CFG;
        else if (i_wr) r_cfg <= i_cfg;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt    <= w_zero ? '0 : r_cnt + 1'b1;
            r_clk_en <= i_en && (r_cnt < r_cfg.high);
            r_tick   <= i_en && (r_cnt == '0);
        end
    end
endmodule

// File: rtl/clk_en_gen.sv
// clk_en_gen: N_CH programmable clock-enable channels behind one valid/ready config port.
// Optional CLKGEN_SHADOW_EN defers writes to period boundaries and backpressures cfg_ready.
module clk_en_gen
    import core_config_pkg::*;
#(
    parameter int N_CH  = CLKGEN_N_CH,
    parameter int CNT_W = CLKGEN_CNT_W,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [N_CH-1:0] ch_enable,
    input  logic            sync,
    output logic [N_CH-1:0] clk_en,
    output logic [N_CH-1:0] tick
);
    clkgen_cfg_t w_cfg;
    logic        w_acc;

    assign w_cfg = '{div: CLKGEN_CNT_W'(cfg_div), high: CLKGEN_CNT_W'(cfg_high)};
    assign w_acc = cfg_valid && cfg_ready;

`ifdef CLKGEN_SHADOW_EN
    logic [N_CH-1:0]      w_pending;
    logic [2**CH_W-1:0]   w_pend_ext;
    // out-of-range channels read a zero pending bit, so their writes are accepted and dropped
    assign w_pend_ext = (2**CH_W)'(w_pending);
    assign cfg_ready  = !w_pend_ext[cfg_ch];
`else
    assign cfg_ready = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        clk_en_channel u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (ch_enable[i]),
            .i_sync   (sync),
            .i_wr     (w_acc && (cfg_ch == CH_W'(i))),
            .i_cfg    (w_cfg),
`ifdef CLKGEN_SHADOW_EN
            .o_pending(w_pending[i]),
`endif
            .o_clk_en (clk_en[i]),
            .o_tick   (tick[i])
        );
    end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed and random stimulus checked against a period-arithmetic model.
// Build with CLKGEN_SHADOW_EN defined to check the deferred-write behaviour.
module tb_clk_en_gen;
`ifdef CLKGEN_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [0:0]  cfg_ch = '0;
    logic [15:0] cfg_div = '0;
    logic [15:0] cfg_high = '0;
    logic [1:0]  ch_enable = '0;
    logic        sync = 1'b0;
    logic [1:0]  clk_en;
    logic [1:0]  tick;

    int n_chk = 0;
    int n_err = 0;

    // model: each channel's phase is its distance from the last period start, modulo div
    int   m_div[2], m_high[2], m_start[2], m_sh_div[2], m_sh_high[2];
    bit   m_pend[2];
    int   cyc;
    logic [1:0] e_clk, e_tick;

    clk_en_gen dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .ch_enable(ch_enable), .sync(sync), .clk_en(clk_en), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_ready();
        return SHADOW ? !m_pend[cfg_ch] : 1'b1;
    endfunction

    task automatic model_reset();
        cyc = 0;
        e_clk = '0;
        e_tick = '0;
        for (int i = 0; i < 2; i++) begin
            m_div[i] = 4; m_high[i] = 2; m_start[i] = 0; m_pend[i] = 0;
            m_sh_div[i] = 4; m_sh_high[i] = 2;
        end
    endtask

    task automatic model_edge();
        bit acc;
        acc = cfg_valid && exp_ready();
        cyc++;
        for (int i = 0; i < 2; i++) begin
            int d, p;
            bit rs, wrap, wr;
            d = (m_div[i] == 0) ? 1 : m_div[i];
            p = (cyc - 1 - m_start[i]) % d;
            e_clk[i]  = ch_enable[i] && (p < m_high[i]);
            e_tick[i] = ch_enable[i] && (p == 0);
            rs   = !ch_enable[i] || sync;
            wrap = (p == d - 1);
            wr   = acc && (int'(cfg_ch) == i);
            if (SHADOW) begin
                if (wr && (rs || wrap)) begin
                    m_div[i] = int'(cfg_div); m_high[i] = int'(cfg_high);
                end else if (wr) begin
                    m_sh_div[i] = int'(cfg_div); m_sh_high[i] = int'(cfg_high); m_pend[i] = 1;
                end else if (m_pend[i] && (rs || wrap)) begin
                    m_div[i] = m_sh_div[i]; m_high[i] = m_sh_high[i]; m_pend[i] = 0;
                end
            end else if (wr) begin
                m_div[i] = int'(cfg_div); m_high[i] = int'(cfg_high);
            end
            if (rs || wrap || (!SHADOW && wr)) m_start[i] = cyc;
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_edge();
            #1;
            for (int i = 0; i < 2; i++) begin
                check($sformatf("clk_en%0d", i), 32'(clk_en[i]), 32'(e_clk[i]));
                check($sformatf("tick%0d", i), 32'(tick[i]), 32'(e_tick[i]));
            end
            check("cfg_ready", 32'(cfg_ready), 32'(exp_ready()));
        end
    endtask

    task automatic write(input int ch, input int dv, input int hi);
        cfg_valid = 1'b1; cfg_ch = 1'(ch); cfg_div = 16'(dv); cfg_high = 16'(hi);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic reset_now();
        rst_n = 1'b0;
        #1;
        check("rst_clk_en", 32'(clk_en), 32'(0));
        check("rst_tick", 32'(tick), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(1));
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_now();
        write(0, 4, 2);
        ch_enable = 2'b01;
        step(12);
        write(0, 0, 1); step(6);
        write(0, 1, 1); step(6);
        write(0, 1, 0); step(6);
        write(0, 5, 9); step(8);
        write(0, 3, 1); step(9);
        write(0, 8, 4);
        sync = 1'b1; step(); sync = 1'b0;
        step();
        write(0, 2, 1);
        cfg_valid = 1'b1; cfg_div = 16'd6; cfg_high = 16'd3;
        step(10);
        cfg_valid = 1'b0;
        step(8);
        write(0, 3, 1);
        write(1, 5, 2);
        step(4);
        ch_enable = 2'b11;
        step(7);
        sync = 1'b1; step(); sync = 1'b0;
        step();
        check("sync_ticks", 32'(tick), 32'(2'b11));
        step(3);
        ch_enable = 2'b01;
        step(4);
        #3;
        reset_now();
        ch_enable = 2'b11;
        step(10);
        for (int k = 0; k < 400; k++) begin
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_ch    = 1'($urandom_range(0, 1));
            cfg_div   = 16'($urandom_range(0, 9));
            cfg_high  = 16'($urandom_range(0, 10));
            sync      = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 19) == 0) ch_enable[0] = ~ch_enable[0];
            if ($urandom_range(0, 19) == 0) ch_enable[1] = ~ch_enable[1];
            step();
        end
        cfg_valid = 1'b0; sync = 1'b0;
        step(5);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
